// File: rtl/riscv_dm_pkg.sv
// Shared debug-module types: hart run-control states and dcsr.cause codes.
package riscv_dm_pkg;

   typedef enum logic [2:0] {
      HC_RST      = 3'd0,
      HC_RUNNING  = 3'd1,
      HC_HALTING  = 3'd2,
      HC_HALTED   = 3'd3,
      HC_PROGBUF  = 3'd4,
      HC_PB_ABORT = 3'd5,
      HC_RESUMING = 3'd6
   } hart_ctrl_state_e;

   localparam logic [2:0] DCSR_CAUSE_EBREAK       = 3'd1;
   localparam logic [2:0] DCSR_CAUSE_HALTREQ      = 3'd3;
   localparam logic [2:0] DCSR_CAUSE_STEP         = 3'd4;
   localparam logic [2:0] DCSR_CAUSE_RESETHALTREQ = 3'd5;

endpackage

// File: rtl/riscv_dm_hart_ctrl.sv
// Per-hart debug run-control sequencer: turns debug-module requests into a
// core-side halt/resume/program-buffer handshake and reports hart status.
module riscv_dm_hart_ctrl
   import riscv_dm_pkg::*;
#(
   parameter int unsigned PROGBUF_TIMEOUT = 1024,
   parameter int unsigned RESET_CYCLES    = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       halt_request_i,
   input  logic       resume_request_i,
   input  logic       progbuf_run_req_i,
   input  logic       halt_on_reset_i,
   input  logic       hart_reset_i,
   input  logic       ack_havereset_i,
   input  logic       step_i,
   output logic       running_o,
   output logic       halted_o,
   output logic       parked_o,
   output logic       resume_ack_o,
   output logic       progbuf_run_ack_o,
   output logic       havereset_o,
   output logic       unavail_o,
   output logic       progbuf_error_o,
   output logic [2:0] cause_o,
   output logic       core_reset_o,
   output logic       core_debug_req_o,
   input  logic       core_debug_ack_i,
   output logic       core_resume_o,
   input  logic       core_resumed_i,
   output logic       core_progbuf_start_o,
   input  logic       core_ebreak_i,
   input  logic       core_exception_i,
   input  logic       core_retire_i,
   input  logic       core_reset_done_i
);

   localparam int unsigned PCW = $clog2(PROGBUF_TIMEOUT + 1);
   localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);
   localparam logic [PCW-1:0] PB_LAST  = PCW'(PROGBUF_TIMEOUT - 1);
   localparam logic [PCW-1:0] PB_MAX   = PCW'(PROGBUF_TIMEOUT);
   localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);

   hart_ctrl_state_e state, state_nx;
   logic [PCW-1:0]   pb_cnt;
   logic [RCW-1:0]   rst_cnt;
   logic             step_armed, step_nx;
   logic [2:0]       cause_nx;
   logic             err_nx;
   logic             pb_start, resume_go, resume_done;
   logic             rst_full, pb_timeout;

   // Saturating program-buffer cycle counter step; it must never wrap.
   function automatic logic [PCW-1:0] pb_cnt_inc(input logic [PCW-1:0] c);
      return (c >= PB_MAX) ? c : c + 1'b1;
   endfunction

   // rst_cnt holds the number of RST cycles already completed before this one.
   assign rst_full   = (rst_cnt >= RST_LAST);
   assign pb_timeout = (pb_cnt >= PB_LAST);

   // Next-state and event decode; hart_reset_i overrides every other event.
   always_comb begin
      state_nx    = state;
      cause_nx    = cause_o;
      step_nx     = step_armed;
      err_nx      = progbuf_error_o;
      pb_start    = 1'b0;
      resume_go   = 1'b0;
      resume_done = 1'b0;
      case (state)
         HC_RST: begin
            if (rst_full && core_reset_done_i) begin
               if (halt_on_reset_i) begin
                  state_nx = HC_HALTING;
                  cause_nx = DCSR_CAUSE_RESETHALTREQ;
                  step_nx  = 1'b0;
               end else begin
                  state_nx = HC_RUNNING;
               end
            end
         end
         HC_RUNNING: begin
            if (halt_request_i) begin
               state_nx = HC_HALTING;
               cause_nx = DCSR_CAUSE_HALTREQ;
               step_nx  = 1'b0;
            end else if (core_ebreak_i) begin
               state_nx = HC_HALTING;
               cause_nx = DCSR_CAUSE_EBREAK;
               step_nx  = 1'b0;
            end else if (step_armed && core_retire_i) begin
               state_nx = HC_HALTING;
               cause_nx = DCSR_CAUSE_STEP;
               step_nx  = 1'b0;
            end
         end
         HC_HALTING: begin
            if (core_debug_ack_i) state_nx = HC_HALTED;
         end
         HC_HALTED: begin
            if (progbuf_run_req_i) begin
               state_nx = HC_PROGBUF;
               pb_start = 1'b1;
               err_nx   = 1'b0;
            end else if (resume_request_i) begin
               state_nx  = HC_RESUMING;
               resume_go = 1'b1;
               step_nx   = step_i;
            end
         end
         HC_PROGBUF: begin
            if (core_ebreak_i) begin
               state_nx = HC_HALTED;
            end else if (core_exception_i) begin
               state_nx = HC_HALTED;
               err_nx   = 1'b1;
            end else if (pb_timeout) begin
               state_nx = HC_PB_ABORT;
               err_nx   = 1'b1;
            end
         end
         HC_PB_ABORT: begin
            if (core_debug_ack_i) state_nx = HC_HALTED;
         end
         HC_RESUMING: begin
            if (core_resumed_i) begin
               state_nx    = HC_RUNNING;
               resume_done = 1'b1;
            end
         end
         default: state_nx = HC_RST;
      endcase
      if (hart_reset_i) begin
         state_nx    = HC_RST;
         cause_nx    = cause_o;
         step_nx     = 1'b0;
         err_nx      = progbuf_error_o;
         pb_start    = 1'b0;
         resume_go   = 1'b0;
         resume_done = 1'b0;
      end
   end

   // State, counters and registered outputs, all derived from the next state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state                <= HC_RST;
         rst_cnt              <= '0;
         pb_cnt               <= '0;
         step_armed           <= 1'b0;
         cause_o              <= '0;
         progbuf_error_o      <= 1'b0;
         havereset_o          <= 1'b1;
         core_reset_o         <= 1'b1;
         unavail_o            <= 1'b1;
         running_o            <= 1'b0;
         halted_o             <= 1'b0;
         parked_o             <= 1'b0;
         core_debug_req_o     <= 1'b0;
         core_resume_o        <= 1'b0;
         core_progbuf_start_o <= 1'b0;
         progbuf_run_ack_o    <= 1'b0;
         resume_ack_o         <= 1'b0;
      end else begin
         state           <= state_nx;
         step_armed      <= step_nx;
         cause_o         <= cause_nx;
         progbuf_error_o <= err_nx;
         if (hart_reset_i)                   rst_cnt <= '0;
         else if (state == HC_RST && !rst_full) rst_cnt <= rst_cnt + 1'b1;
         if (pb_start)                 pb_cnt <= '0;
         else if (state == HC_PROGBUF) pb_cnt <= pb_cnt_inc(pb_cnt);
         if (hart_reset_i)         havereset_o <= 1'b1;
         else if (ack_havereset_i) havereset_o <= 1'b0;
         core_reset_o         <= (state_nx == HC_RST);
         unavail_o            <= (state_nx == HC_RST);
         running_o            <= (state_nx == HC_RUNNING);
         halted_o             <= (state_nx == HC_HALTED) || (state_nx == HC_PROGBUF) ||
                                 (state_nx == HC_PB_ABORT);
         parked_o             <= (state_nx == HC_HALTED);
         core_debug_req_o     <= (state_nx == HC_HALTING) || (state_nx == HC_PB_ABORT);
         core_resume_o        <= resume_go;
         core_progbuf_start_o <= pb_start;
         progbuf_run_ack_o    <= pb_start;
         resume_ack_o         <= resume_done;
      end
   end

endmodule

// File: tb/tb_riscv_dm_hart_ctrl.sv
// Scenario bench for riscv_dm_hart_ctrl with randomized timing and event mixes.
module tb_riscv_dm_hart_ctrl;

   localparam int PBT = 8;
   localparam int RC  = 4;

   // Status patterns {core_reset, unavail, running, halted, parked, debug_req} per phase.
   localparam logic [5:0] E_RST      = 6'b110000;
   localparam logic [5:0] E_RUN      = 6'b001000;
   localparam logic [5:0] E_HALTING  = 6'b000001;
   localparam logic [5:0] E_HALTED   = 6'b000110;
   localparam logic [5:0] E_PROGBUF  = 6'b000100;
   localparam logic [5:0] E_PBABORT  = 6'b000101;
   localparam logic [5:0] E_RESUMING = 6'b000000;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   logic halt_request_i = 0, resume_request_i = 0, progbuf_run_req_i = 0;
   logic halt_on_reset_i = 0, hart_reset_i = 0, ack_havereset_i = 0, step_i = 0;
   logic core_debug_ack_i = 0, core_resumed_i = 0, core_ebreak_i = 0;
   logic core_exception_i = 0, core_retire_i = 0, core_reset_done_i = 0;
   logic running_o, halted_o, parked_o, resume_ack_o, progbuf_run_ack_o;
   logic havereset_o, unavail_o, progbuf_error_o, core_reset_o;
   logic core_debug_req_o, core_resume_o, core_progbuf_start_o;
   logic [2:0] cause_o;

   int checks = 0;
   int passes = 0;

   // Reference model state, updated from the rules as events are applied.
   bit       m_havereset;
   bit       m_err;
   bit [2:0] m_cause;

   wire [7:0] st = {core_reset_o, unavail_o, running_o, halted_o, parked_o,
                    core_debug_req_o, havereset_o, progbuf_error_o};
   wire [3:0] pl = {core_resume_o, core_progbuf_start_o, progbuf_run_ack_o, resume_ack_o};

   riscv_dm_hart_ctrl #(.PROGBUF_TIMEOUT(PBT), .RESET_CYCLES(RC)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .halt_request_i(halt_request_i), .resume_request_i(resume_request_i),
      .progbuf_run_req_i(progbuf_run_req_i), .halt_on_reset_i(halt_on_reset_i),
      .hart_reset_i(hart_reset_i), .ack_havereset_i(ack_havereset_i), .step_i(step_i),
      .running_o(running_o), .halted_o(halted_o), .parked_o(parked_o),
      .resume_ack_o(resume_ack_o), .progbuf_run_ack_o(progbuf_run_ack_o),
      .havereset_o(havereset_o), .unavail_o(unavail_o),
      .progbuf_error_o(progbuf_error_o), .cause_o(cause_o),
      .core_reset_o(core_reset_o), .core_debug_req_o(core_debug_req_o),
      .core_debug_ack_i(core_debug_ack_i), .core_resume_o(core_resume_o),
      .core_resumed_i(core_resumed_i), .core_progbuf_start_o(core_progbuf_start_o),
      .core_ebreak_i(core_ebreak_i), .core_exception_i(core_exception_i),
      .core_retire_i(core_retire_i), .core_reset_done_i(core_reset_done_i)
   );

   always #5 clk = ~clk;

   // Halt cause implied by simultaneous RUNNING events; 0 means the hart keeps running.
   function automatic bit [2:0] ref_cause(input bit hreq, input bit ebrk, input bit retire,
                                          input bit armed);
      if (hreq) return 3'd3;
      if (ebrk) return 3'd1;
      if (armed && retire) return 3'd4;
      return 3'd0;
   endfunction

   // Program-buffer error outcome: ebreak always ends cleanly.
   function automatic bit ref_pb_err(input bit ebrk, input bit exc, input bit tmo);
      return !ebrk && (exc || tmo);
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   // Resume from HALTED and complete the core handshake; ends in RUNNING.
   task automatic go_run(input bit stp);
      resume_request_i = 1; step_i = stp; cyc();
      resume_request_i = 0; step_i = 0; cyc();
      core_resumed_i = 1; cyc();
      core_resumed_i = 0;
   endtask

   task automatic test_reset();
      int n;
      halt_on_reset_i = 1; core_reset_done_i = 1; rst_i = 1;
      repeat (2) cyc();
      m_havereset = 1; m_err = 0; m_cause = 0;
      checks++;
      if ({st, pl, cause_o} !== {E_RST, 2'b10, 4'b0, 3'd0})
         $display("FAIL reset_values got=%b/%b/%0d want=%b/0000/0", st, pl, cause_o, {E_RST, 2'b10});
      else passes++;
      rst_i = 0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(); n++;
         if (!core_reset_o) break;
      end
      checks++;
      if (n !== RC) $display("FAIL reset_hold got=%0d want=%0d", n, RC);
      else passes++;
      m_cause = 3'd5;
      checks++;
      if ({st, cause_o} !== {E_HALTING, m_havereset, m_err, m_cause})
         $display("FAIL halt_on_reset got=%b/%0d want=%b/%0d", st, cause_o,
                  {E_HALTING, m_havereset, m_err}, m_cause);
      else passes++;
      repeat ($urandom_range(0, 3)) cyc();
      checks++;
      if (core_debug_req_o !== 1'b1) $display("FAIL halting_hold got=%b want=1", core_debug_req_o);
      else passes++;
      core_debug_ack_i = 1; cyc(); core_debug_ack_i = 0;
      checks++;
      if ({st, cause_o} !== {E_HALTED, m_havereset, m_err, m_cause})
         $display("FAIL reset_halted got=%b/%0d want=%b/%0d", st, cause_o,
                  {E_HALTED, m_havereset, m_err}, m_cause);
      else passes++;
      repeat ($urandom_range(1, 4)) cyc();
      checks++;
      if (havereset_o !== m_havereset) $display("FAIL havereset_hold got=%b want=%b", havereset_o, m_havereset);
      else passes++;
      ack_havereset_i = 1; cyc(); ack_havereset_i = 0;
      m_havereset = 0;
      checks++;
      if (havereset_o !== m_havereset) $display("FAIL havereset_ack got=%b want=%b", havereset_o, m_havereset);
      else passes++;
      halt_on_reset_i = 0;
   endtask

   task automatic test_halt_resume();
      int d, sel;
      bit h, e;
      for (int it = 0; it < 3; it++) begin
         d = (it == 0) ? 3 : $urandom_range(1, 5);
         resume_request_i = 1; cyc(); resume_request_i = 0;
         checks++;
         if ({st, pl} !== {E_RESUMING, m_havereset, m_err, 4'b1000})
            $display("FAIL resume_issue got=%b/%b want=%b/1000", st, pl, {E_RESUMING, m_havereset, m_err});
         else passes++;
         cyc();
         checks++;
         if ({st, pl} !== {E_RESUMING, m_havereset, m_err, 4'b0000})
            $display("FAIL resume_pulse_width got=%b/%b want=%b/0000", st, pl, {E_RESUMING, m_havereset, m_err});
         else passes++;
         repeat (d - 1) cyc();
         core_resumed_i = 1; cyc(); core_resumed_i = 0;
         checks++;
         if ({st, pl} !== {E_RUN, m_havereset, m_err, 4'b0001})
            $display("FAIL resume_ack got=%b/%b want=%b/0001", st, pl, {E_RUN, m_havereset, m_err});
         else passes++;
         cyc();
         checks++;
         if ({st, pl} !== {E_RUN, m_havereset, m_err, 4'b0000})
            $display("FAIL resume_ack_width got=%b/%b want=%b/0000", st, pl, {E_RUN, m_havereset, m_err});
         else passes++;
         sel = (it == 0) ? 1 : $urandom_range(1, 3);
         h = sel[0]; e = sel[1];
         halt_request_i = h; core_ebreak_i = e; cyc();
         halt_request_i = 0; core_ebreak_i = 0;
         m_cause = ref_cause(h, e, 1'b0, 1'b0);
         checks++;
         if ({st, cause_o} !== {E_HALTING, m_havereset, m_err, m_cause})
            $display("FAIL halt_cause got=%b/%0d want=%b/%0d", st, cause_o,
                     {E_HALTING, m_havereset, m_err}, m_cause);
         else passes++;
         core_debug_ack_i = 1; cyc(); core_debug_ack_i = 0;
         checks++;
         if ({st, cause_o} !== {E_HALTED, m_havereset, m_err, m_cause})
            $display("FAIL halted got=%b/%0d want=%b/%0d", st, cause_o,
                     {E_HALTED, m_havereset, m_err}, m_cause);
         else passes++;
      end
      halt_request_i = 1; repeat (3) cyc(); halt_request_i = 0;
      checks++;
      if ({st, cause_o} !== {E_HALTED, m_havereset, m_err, m_cause})
         $display("FAIL halt_ignored got=%b/%0d want=%b/%0d", st, cause_o,
                  {E_HALTED, m_havereset, m_err}, m_cause);
      else passes++;
   endtask

   task automatic test_progbuf();
      int kind;
      bit e, x;
      for (int it = 0; it < 4; it++) begin
         kind = (it == 0) ? 2 : (it == 1) ? 1 : $urandom_range(1, 3);
         e = kind[0]; x = kind[1];
         progbuf_run_req_i = 1; resume_request_i = 1; cyc();
         progbuf_run_req_i = 0; resume_request_i = 0;
         m_err = 0;
         checks++;
         if ({st, pl} !== {E_PROGBUF, m_havereset, m_err, 4'b0110})
            $display("FAIL pb_start got=%b/%b want=%b/0110", st, pl, {E_PROGBUF, m_havereset, m_err});
         else passes++;
         cyc();
         checks++;
         if ({st, pl} !== {E_PROGBUF, m_havereset, m_err, 4'b0000})
            $display("FAIL pb_pulse_width got=%b/%b want=%b/0000", st, pl, {E_PROGBUF, m_havereset, m_err});
         else passes++;
         repeat ($urandom_range(0, 4)) cyc();
         core_ebreak_i = e; core_exception_i = x; cyc();
         core_ebreak_i = 0; core_exception_i = 0;
         m_err = ref_pb_err(e, x, 1'b0);
         checks++;
         if ({st, pl} !== {E_HALTED, m_havereset, m_err, 4'b0000})
            $display("FAIL pb_done kind=%0d got=%b/%b want=%b/0000", kind, st, pl, {E_HALTED, m_havereset, m_err});
         else passes++;
      end
   endtask

   task automatic test_pb_timeout();
      int n;
      progbuf_run_req_i = 1; cyc(); progbuf_run_req_i = 0;
      m_err = 0;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(); n++;
         if (core_debug_req_o) break;
      end
      checks++;
      if (n !== PBT) $display("FAIL pb_timeout_cycles got=%0d want=%0d", n, PBT);
      else passes++;
      m_err = ref_pb_err(1'b0, 1'b0, 1'b1);
      checks++;
      if (st !== {E_PBABORT, m_havereset, m_err})
         $display("FAIL pb_abort got=%b want=%b", st, {E_PBABORT, m_havereset, m_err});
      else passes++;
      repeat ($urandom_range(0, 3)) cyc();
      core_debug_ack_i = 1; cyc(); core_debug_ack_i = 0;
      checks++;
      if (st !== {E_HALTED, m_havereset, m_err})
         $display("FAIL pb_abort_ack got=%b want=%b", st, {E_HALTED, m_havereset, m_err});
      else passes++;
      progbuf_run_req_i = 1; cyc(); progbuf_run_req_i = 0;
      m_err = 0;
      repeat (PBT - 1) cyc();
      checks++;
      if (st !== {E_PROGBUF, m_havereset, m_err})
         $display("FAIL pb_before_timeout got=%b want=%b", st, {E_PROGBUF, m_havereset, m_err});
      else passes++;
      core_ebreak_i = 1; cyc(); core_ebreak_i = 0;
      m_err = ref_pb_err(1'b1, 1'b0, 1'b1);
      checks++;
      if (st !== {E_HALTED, m_havereset, m_err})
         $display("FAIL pb_ebreak_vs_timeout got=%b want=%b", st, {E_HALTED, m_havereset, m_err});
      else passes++;
   endtask

   task automatic test_step();
      bit [2:0] c;
      go_run(1'b1);
      repeat ($urandom_range(1, 4)) begin
         step_i = 1'($urandom_range(0, 1)); cyc();
      end
      step_i = 0;
      checks++;
      if (st !== {E_RUN, m_havereset, m_err})
         $display("FAIL step_wait got=%b want=%b", st, {E_RUN, m_havereset, m_err});
      else passes++;
      core_retire_i = 1; cyc(); core_retire_i = 0;
      m_cause = ref_cause(1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({st, cause_o} !== {E_HALTING, m_havereset, m_err, m_cause})
         $display("FAIL step_halt got=%b/%0d want=%b/%0d", st, cause_o,
                  {E_HALTING, m_havereset, m_err}, m_cause);
      else passes++;
      core_debug_ack_i = 1; cyc(); core_debug_ack_i = 0;
      go_run(1'b0);
      c = 3'd0;
      for (int i = 0; i < 3; i++) begin
         core_retire_i = 1; cyc();
         if (ref_cause(1'b0, 1'b0, 1'b1, 1'b0) != 3'd0) c = 3'd7;
      end
      core_retire_i = 0;
      checks++;
      if (st !== {(c == 3'd0) ? E_RUN : E_HALTING, m_havereset, m_err})
         $display("FAIL no_step_retire got=%b want=%b", st, {E_RUN, m_havereset, m_err});
      else passes++;
      halt_request_i = 1; cyc(); halt_request_i = 0;
      core_debug_ack_i = 1; cyc(); core_debug_ack_i = 0;
      go_run(1'b1);
      halt_request_i = 1; core_retire_i = 1; cyc();
      halt_request_i = 0; core_retire_i = 0;
      m_cause = ref_cause(1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({st, cause_o} !== {E_HALTING, m_havereset, m_err, m_cause})
         $display("FAIL step_vs_haltreq got=%b/%0d want=%b/%0d", st, cause_o,
                  {E_HALTING, m_havereset, m_err}, m_cause);
      else passes++;
      core_debug_ack_i = 1; cyc(); core_debug_ack_i = 0;
   endtask

   task automatic test_reset_mid();
      int n;
      progbuf_run_req_i = 1; cyc(); progbuf_run_req_i = 0;
      m_err = 0;
      repeat (2) cyc();
      core_reset_done_i = 0; hart_reset_i = 1; ack_havereset_i = 1; core_ebreak_i = 1; cyc();
      hart_reset_i = 0; ack_havereset_i = 0; core_ebreak_i = 0;
      m_havereset = 1;
      checks++;
      if ({st, pl} !== {E_RST, m_havereset, m_err, 4'b0000})
         $display("FAIL hart_reset_mid got=%b/%b want=%b/0000", st, pl, {E_RST, m_havereset, m_err});
      else passes++;
      repeat ($urandom_range(6, 10)) cyc();
      checks++;
      if (st !== {E_RST, m_havereset, m_err})
         $display("FAIL reset_done_gate got=%b want=%b", st, {E_RST, m_havereset, m_err});
      else passes++;
      core_reset_done_i = 1; cyc();
      checks++;
      if ({st, cause_o} !== {E_RUN, m_havereset, m_err, m_cause})
         $display("FAIL reset_to_run got=%b/%0d want=%b/%0d", st, cause_o,
                  {E_RUN, m_havereset, m_err}, m_cause);
      else passes++;
      ack_havereset_i = 1; cyc(); ack_havereset_i = 0;
      m_havereset = 0;
      hart_reset_i = 1; halt_request_i = 1; cyc();
      hart_reset_i = 0; halt_request_i = 0;
      m_havereset = 1;
      checks++;
      if (st !== {E_RST, m_havereset, m_err})
         $display("FAIL hart_reset_priority got=%b want=%b", st, {E_RST, m_havereset, m_err});
      else passes++;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(); n++;
         if (!core_reset_o) break;
      end
      checks++;
      if (n !== RC) $display("FAIL hart_reset_hold got=%0d want=%0d", n, RC);
      else passes++;
   endtask

   task automatic test_async_rst();
      halt_request_i = 1; cyc(); halt_request_i = 0;
      #2 rst_i = 1;
      #1;
      m_havereset = 1; m_err = 0; m_cause = 0;
      checks++;
      if ({st, pl, cause_o} !== {E_RST, m_havereset, m_err, 4'b0, m_cause})
         $display("FAIL async_reset got=%b/%b/%0d want=%b/0000/0", st, pl, cause_o,
                  {E_RST, m_havereset, m_err});
      else passes++;
      cyc(); rst_i = 0;
      repeat (RC) cyc();
      checks++;
      if (st !== {E_RUN, m_havereset, m_err})
         $display("FAIL async_reset_release got=%b want=%b", st, {E_RUN, m_havereset, m_err});
      else passes++;
   endtask

   initial begin
      test_reset();
      test_halt_resume();
      test_progbuf();
      test_pb_timeout();
      test_step();
      test_reset_mid();
      test_async_rst();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/riscv_dm_hart_ctrl.md
# riscv_dm_hart_ctrl

Per-hart debug run-control sequencer, downstream of the debug module (`riscv_dm`). It consumes that module's hart-control requests (halt, resume, program-buffer run, reset, halt-on-reset) and drives a simple core-side debug handshake. It returns the status levels and acknowledges the debug module expects (running, halted, parked, resume ack, program-buffer ack, havereset, unavail). One instance is built per hart; the instance index selects the hart's bit of each debug-module bus.

## Interface
- `PROGBUF_TIMEOUT`, 1024: maximum cycles allowed in program-buffer execution before abort; must be ≥2.
- `RESET_CYCLES`, 4: minimum cycles `core_reset_o` is held; must be ≥1.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `halt_request_i` in 1: level from the debug module.
- `resume_request_i` in 1: level from the debug module.
- `progbuf_run_req_i` in 1: level from the debug module.
- `halt_on_reset_i` in 1: level from the debug module.
- `hart_reset_i` in 1: level from the debug module.
- `ack_havereset_i` in 1: pulse; clears `havereset_o`.
- `step_i` in 1: `dcsr.step`, sampled on resume.
- `running_o` out 1: status to the debug module.
- `halted_o` out 1: status to the debug module.
- `parked_o` out 1: status to the debug module.
- `resume_ack_o` out 1: status to the debug module.
- `progbuf_run_ack_o` out 1: status to the debug module.
- `havereset_o` out 1: status to the debug module.
- `unavail_o` out 1: status to the debug module.
- `progbuf_error_o` out 1: sticky error; cleared on the next program-buffer start.
- `cause_o` out 3: `dcsr.cause` of the last halt.
- `core_reset_o` out 1: core reset.
- `core_debug_req_o` out 1: level; core must drain and enter debug mode.
- `core_debug_ack_i` in 1: pulse; core is in debug mode.
- `core_resume_o` out 1: pulse.
- `core_resumed_i` in 1: pulse.
- `core_progbuf_start_o` out 1: pulse; core jumps to the program buffer.
- `core_ebreak_i` in 1: core executed ebreak.
- `core_exception_i` in 1: core took an exception.
- `core_retire_i` in 1: core retired an instruction.
- `core_reset_done_i` in 1: core has left reset.

## Operation
- FSM states: RST, RUNNING, HALTING, HALTED, PROGBUF, PB_ABORT, RESUMING.
- Cause codes: 1 ebreak, 3 haltreq, 4 step, 5 resethaltreq.
- **RST**
  - `core_reset_o`=1, `unavail_o`=1, reset counter counting.
  - Exit when the counter has reached `RESET_CYCLES` AND `core_reset_done_i`=1.
  - Exit to HALTING with cause 5 if `halt_on_reset_i`=1; otherwise to RUNNING.
- **hart_reset_i**
  - From any state, `hart_reset_i`=1 forces RST, reloads the counter and sets `havereset_o`.
  - It has priority over every other event.
  - `ack_havereset_i` clears `havereset_o`. If both arrive in the same cycle, set wins.
- **RUNNING**
  - `running_o`=1.
  - `halt_request_i` → HALTING, cause 3.
  - Else `core_ebreak_i` → HALTING, cause 1.
  - Else, if a step is armed and `core_retire_i`=1 → HALTING, cause 4.
  - The step flag is cleared on every HALTING entry.
- **HALTING**
  - `core_debug_req_o`=1 until `core_debug_ack_i` → HALTED.
- **HALTED**
  - `halted_o`=1, `parked_o`=1.
  - `progbuf_run_req_i` has priority over `resume_request_i`.
  - Program-buffer start: `core_progbuf_start_o` and `progbuf_run_ack_o` pulse together; clear `progbuf_error_o` and the timeout counter; → PROGBUF.
  - Resume: `core_resume_o` pulses; latch `step_i` into the step flag; → RESUMING.
  - `halt_request_i` while HALTED is ignored.
- **PROGBUF**
  - `halted_o`=1, `parked_o`=0; the counter increments each cycle.
  - `core_ebreak_i` → HALTED.
  - Else `core_exception_i` → HALTED with `progbuf_error_o`=1.
  - Else, when the counter reaches `PROGBUF_TIMEOUT`-1 → PB_ABORT with `progbuf_error_o`=1.
- **PB_ABORT**
  - `halted_o`=1, `core_debug_req_o`=1 until `core_debug_ack_i` → HALTED.
- **RESUMING**
  - `core_resumed_i` → `resume_ack_o` one-cycle pulse, → RUNNING.
  - `halt_request_i` is not acted on until RUNNING is reached.
- `cause_o` updates only on HALTING entry and holds its value otherwise.

## Timing
- All outputs are registered.
- Reset values:
  - `core_reset_o`=1, `unavail_o`=1, `havereset_o`=1, state RST, counters 0.
  - All other outputs 0, `cause_o`=0.
- Input sampled in cycle N → state change and output update in N+1.
- Pulses (`core_resume_o`, `core_progbuf_start_o`, `progbuf_run_ack_o`, `resume_ack_o`) are exactly one cycle wide.
- `halted_o` is 0 in the cycle `core_resume_o` is issued; `running_o` rises with `resume_ack_o`.
- Timeout counter width is `$clog2(PROGBUF_TIMEOUT+1)` and saturates; it never wraps.
- `core_ebreak_i` and timeout in the same cycle → ebreak wins, no error.
- `rst_i` mid-operation aborts immediately to the reset values; no pulse is emitted.

## Structure
- `riscv_dm_pkg` gains:
  - `hart_ctrl_state_e` enum.
  - `DCSR_CAUSE_EBREAK`/`HALTREQ`/`STEP`/`RESETHALTREQ` 3-bit constants.
- No sub-module: one FSM plus two counters.
- `riscv_dm_wrapper`-level integration instantiates one per hart in a generate loop.

## Test plan
- **Reset and halt-on-reset.** Release `rst_i` with `halt_on_reset_i`=1 and `core_reset_done_i`=1 → `core_reset_o` falls after 4 cycles, then `core_debug_req_o`=1. Ack → `halted_o`=1, `cause_o`=5, `havereset_o`=1 until `ack_havereset_i`.
- **Halt and resume.** `halt_request_i` in RUNNING → HALTED with `cause_o`=3. `resume_request_i` → `core_resume_o` pulse; `core_resumed_i` 3 cycles later → `resume_ack_o` pulse, `running_o`=1.
- **Program buffer, normal and exception.** With `progbuf_run_req_i`=1 and `resume_request_i`=1 together in HALTED → `progbuf_run_ack_o` pulse, no `core_resume_o`. `core_ebreak_i` → `parked_o`=1, `progbuf_error_o`=0. Repeat with `core_exception_i` → `progbuf_error_o`=1.
- **Program-buffer timeout.** `PROGBUF_TIMEOUT`=8 with no core response → PB_ABORT at cycle 8, `core_debug_req_o`=1; ack → HALTED, `progbuf_error_o`=1.
- **Single step.** Resume with `step_i`=1, then `core_retire_i` pulse → HALTING, `cause_o`=4.
- **Reset mid-operation.** `hart_reset_i` asserted during PROGBUF → next cycle `core_reset_o`=1, `unavail_o`=1, `halted_o`=0, `havereset_o`=1.
